// File: rtl/tft_pattern_sequencer_if.sv
// tft_pattern_sequencer_if: frame sync, raw keys and colour outputs between the sequencer and its environment.
interface tft_pattern_sequencer_if;
    logic        vs_in;
    logic        key_next_n;
    logic        key_mode_n;
    logic [7:0]  color_mode;
    logic [15:0] disp_data;
    logic        auto_en;
    logic        frame_tick;
    modport master (output vs_in, key_next_n, key_mode_n,
                    input  color_mode, disp_data, auto_en, frame_tick);
    modport slave  (input  vs_in, key_next_n, key_mode_n,
                    output color_mode, disp_data, auto_en, frame_tick);
endinterface

// File: rtl/tft_pattern_sequencer.sv
// tft_pattern_sequencer: solid-colour TFT test pattern, stepped by key or every N frames, changed only at frame start.
module tft_pattern_sequencer #(
    parameter int DEBOUNCE_CYCLES = 660000,
    parameter int FRAMES_PER_STEP = 60,
    parameter bit VS_ACTIVE_LOW   = 1'b1
) (
    input logic clk,
    input logic rst_n,
    tft_pattern_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] FR_LAST = 16'(FRAMES_PER_STEP - 1);

    typedef enum logic {MANUAL, AUTO} state_t;

    logic [1:0]    raw, s1, s2, acc, press;
    logic [DW-1:0] cnt [2];
    logic          vs_d1, vs_d2, frame_tick;
    state_t        state;
    logic          pending, auto_en, adv, onehot;
    logic [15:0]   fcnt;
    logic [7:0]    color_mode, color_nxt;
    logic [15:0]   disp_data;

    function automatic logic [15:0] rgb(input logic [7:0] c);
        case (c)
            8'h02:   rgb = 16'h001F;
            8'h04:   rgb = 16'hF800;
            8'h08:   rgb = 16'hF81F;
            8'h10:   rgb = 16'h07E0;
            8'h20:   rgb = 16'h07FF;
            8'h40:   rgb = 16'hFFE0;
            8'h80:   rgb = 16'hFFFF;
            default: rgb = 16'h0000;
        endcase
    endfunction

    assign raw = {bus.key_mode_n, bus.key_next_n};

    // Bit 0 is the next key, bit 1 the mode key; the counter runs only while the level disagrees with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 2'b11;
            s2    <= 2'b11;
            acc   <= 2'b11;
            press <= 2'b00;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= acc[i] && !s2[i] && cnt[i] == DB_LAST;
                if (s2[i] == acc[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    acc[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1      <= VS_ACTIVE_LOW;
            vs_d2      <= VS_ACTIVE_LOW;
            frame_tick <= 1'b0;
        end else begin
            vs_d1      <= bus.vs_in;
            vs_d2      <= vs_d1;
            frame_tick <= (vs_d1 ^ VS_ACTIVE_LOW) && !(vs_d2 ^ VS_ACTIVE_LOW);
        end
    end

    always_comb begin
        onehot    = color_mode != 8'h00 && (color_mode & (color_mode - 8'd1)) == 8'h00;
        adv       = frame_tick && !press[1] && (pending || press[0] || (state == AUTO && fcnt == FR_LAST));
        color_nxt = (frame_tick && !onehot) ? 8'h01 : adv ? {color_mode[6:0], color_mode[7]} : color_mode;
    end

    // A mode press outranks everything, so a coincident next press is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MANUAL;
            pending    <= 1'b0;
            fcnt       <= 16'd0;
            auto_en    <= 1'b0;
            color_mode <= 8'h01;
            disp_data  <= 16'h0000;
        end else begin
            auto_en    <= state == AUTO;
            color_mode <= color_nxt;
            disp_data  <= rgb(color_nxt);
            if (press[1]) begin
                state   <= (state == AUTO) ? MANUAL : AUTO;
                pending <= 1'b0;
                fcnt    <= 16'd0;
            end else if (frame_tick) begin
                pending <= 1'b0;
                fcnt    <= (adv || state == MANUAL) ? 16'd0 : fcnt + 16'd1;
            end else if (press[0]) begin
                pending <= 1'b1;
                fcnt    <= 16'd0;
            end
        end
    end

    assign bus.color_mode = color_mode;
    assign bus.disp_data  = disp_data;
    assign bus.auto_en    = auto_en;
    assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_tft_pattern_sequencer.sv
// tb_tft_pattern_sequencer: directed scenarios with hand-computed colours for the TFT pattern sequencer.
module tb_tft_pattern_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    tft_pattern_sequencer_if bif ();

    tft_pattern_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .FRAMES_PER_STEP(3),
        .VS_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif.slave)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        bif.vs_in = 1'b1;
        bif.key_next_n = 1'b1;
        bif.key_mode_n = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // vs_in falls just after one edge; frame_tick must be high only after the second edge following it.
    task automatic frame();
        @(posedge clk);
        #1 bif.vs_in = 1'b0;
        @(posedge clk);
        #1 n_checks++;
        if (bif.frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_early got %b want 0", bif.frame_tick); end
        @(posedge clk);
        #1 n_checks++;
        if (bif.frame_tick !== 1'b1) begin n_fail++; $display("FAIL tick_high got %b want 1", bif.frame_tick); end
        @(posedge clk);
        #1 n_checks++;
        if (bif.frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_width got %b want 0", bif.frame_tick); end
        repeat (2) @(posedge clk);
        #1 bif.vs_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic nxt, input logic mode);
        bif.key_next_n = !nxt;
        bif.key_mode_n = !mode;
        repeat (10) @(posedge clk);
        #1 bif.key_next_n = 1'b1;
        bif.key_mode_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bif.vs_in = 1'b1;
        bif.key_next_n = 1'b1;
        bif.key_mode_n = 1'b1;
        rst_n = 1'b0;
        #12 n_checks++;
        if (bif.color_mode !== 8'h01 || bif.disp_data !== 16'h0000 || bif.auto_en !== 1'b0 || bif.frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals got %h/%h/%b/%b want 01/0000/0/0", bif.color_mode, bif.disp_data, bif.auto_en, bif.frame_tick);
        end
        apply_reset();
        for (int f = 0; f < 5; f++) begin
            frame();
            n_checks++;
            if (bif.color_mode !== 8'h01 || bif.disp_data !== 16'h0000 || bif.auto_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_frame%0d got %h/%h/%b want 01/0000/0", f, bif.color_mode, bif.disp_data, bif.auto_en);
            end
        end
    endtask

    task automatic test_manual();
        logic [7:0]  ec [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        logic [15:0] ed [8] = '{16'h001F, 16'hF800, 16'hF81F, 16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF, 16'h0000};
        logic [7:0]  prev = 8'h01;
        for (int s = 0; s < 8; s++) begin
            press(1'b1, 1'b0);
            n_checks++;
            if (bif.color_mode !== prev) begin
                n_fail++;
                $display("FAIL manual_hold%0d got %h want %h", s, bif.color_mode, prev);
            end
            frame();
            n_checks++;
            if (bif.color_mode !== ec[s] || bif.disp_data !== ed[s]) begin
                n_fail++;
                $display("FAIL manual_step%0d got %h/%h want %h/%h", s, bif.color_mode, bif.disp_data, ec[s], ed[s]);
            end
            prev = ec[s];
        end
    endtask

    task automatic test_bounce();
        for (int b = 0; b < 5; b++) begin
            bif.key_next_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 bif.key_next_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h01) begin n_fail++; $display("FAIL bounce_reject got %h want 01", bif.color_mode); end
        repeat (3) press(1'b1, 1'b0);
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h02 || bif.disp_data !== 16'h001F) begin
            n_fail++;
            $display("FAIL collapse got %h/%h want 02/001F", bif.color_mode, bif.disp_data);
        end
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h02) begin n_fail++; $display("FAIL collapse_once got %h want 02", bif.color_mode); end
    endtask

    task automatic test_auto();
        logic [7:0] ec [9] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04, 8'h04, 8'h08};
        apply_reset();
        press(1'b0, 1'b1);
        n_checks++;
        if (bif.auto_en !== 1'b1) begin n_fail++; $display("FAIL auto_on got %b want 1", bif.auto_en); end
        for (int f = 0; f < 9; f++) begin
            frame();
            n_checks++;
            if (bif.color_mode !== ec[f]) begin
                n_fail++;
                $display("FAIL auto_frame%0d got %h want %h", f + 1, bif.color_mode, ec[f]);
            end
        end
        n_checks++;
        if (bif.disp_data !== 16'hF81F) begin n_fail++; $display("FAIL auto_disp got %h want F81F", bif.disp_data); end
        press(1'b0, 1'b1);
        n_checks++;
        if (bif.auto_en !== 1'b0 || bif.color_mode !== 8'h08) begin
            n_fail++;
            $display("FAIL auto_off got %b/%h want 0/08", bif.auto_en, bif.color_mode);
        end
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h08) begin n_fail++; $display("FAIL manual_hold got %h want 08", bif.color_mode); end
    endtask

    task automatic test_auto_next();
        logic [7:0] ec [4] = '{8'h02, 8'h02, 8'h02, 8'h04};
        apply_reset();
        press(1'b0, 1'b1);
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h01) begin n_fail++; $display("FAIL an_frame1 got %h want 01", bif.color_mode); end
        press(1'b1, 1'b0);
        for (int f = 0; f < 4; f++) begin
            frame();
            n_checks++;
            if (bif.color_mode !== ec[f]) begin
                n_fail++;
                $display("FAIL an_frame%0d got %h want %h", f + 2, bif.color_mode, ec[f]);
            end
        end
        press(1'b1, 1'b1);
        n_checks++;
        if (bif.auto_en !== 1'b0) begin n_fail++; $display("FAIL both_mode got %b want 0", bif.auto_en); end
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h04) begin n_fail++; $display("FAIL both_no_adv got %h want 04", bif.color_mode); end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        press(1'b0, 1'b1);
        for (int s = 0; s < 6; s++) begin
            press(1'b1, 1'b0);
            frame();
        end
        n_checks++;
        if (bif.color_mode !== 8'h40 || bif.disp_data !== 16'hFFE0 || bif.auto_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_40 got %h/%h/%b want 40/FFE0/1", bif.color_mode, bif.disp_data, bif.auto_en);
        end
        press(1'b1, 1'b0);
        bif.key_next_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 n_checks++;
        if (bif.color_mode !== 8'h01 || bif.disp_data !== 16'h0000 || bif.auto_en !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst got %h/%h/%b want 01/0000/0", bif.color_mode, bif.disp_data, bif.auto_en);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bif.key_next_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h01 || bif.auto_en !== 1'b0) begin
            n_fail++;
            $display("FAIL no_pending got %h/%b want 01/0", bif.color_mode, bif.auto_en);
        end
        press(1'b0, 1'b1);
        frame();
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h01) begin n_fail++; $display("FAIL cnt_cleared got %h want 01", bif.color_mode); end
        frame();
        n_checks++;
        if (bif.color_mode !== 8'h02) begin n_fail++; $display("FAIL cnt_third got %h want 02", bif.color_mode); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_bounce();
        test_auto();
        test_auto_next();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
